rvvi_packetizer: RTL and testbench
==================================

// Module: rvvi_packetizer
// PURPOSE
//  Sits directly downstream of rvvisynth. Captures one compressed RVVI record per retired instruction
//  and serialises only its meaningful bytes (CSR slots trimmed to CSRCount) onto an AXI4-Stream master
//  as one frame per record, e.g. for an Ethernet MAC. Asserts RVVIStall while a record is in flight
//  so the core holds retirement; records arriving while busy are dropped and counted.
// PARAMETERS
//  P         cvw_t   core config; P.XLEN sets field widths (32 or 64)
//  MAX_CSRS  5       CSR slots in rvvi; must match rvvisynth
//  AXIW      32      stream data width in bits; one of 8/16/32/64
//  GAP       4       idle cycles forced between frames (0 allowed)
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  En         in   1      1 = accept records; 0 = ignore valid (not counted as drops)
//  valid      in   1      rvvi holds a retired-instruction record this cycle
//  rvvi       in   W      W = 72+5*XLEN+MAX_CSRS*(XLEN+16); packed record, bit 0 = PC lsb
//  TDATA      out  AXIW   stream beat data
//  TKEEP      out  AXIW/8 byte enables; all-ones except possibly the last beat
//  TVALID     out  1      beat valid
//  TLAST      out  1      final beat of frame
//  TREADY     in   1      sink accepts beat
//  RVVIStall  out  1      core must stall writeback
//  DropCount  out  16     saturating count of records lost while busy
// BEHAVIOUR
//  Reset: state IDLE; TVALID=0, TLAST=0, TKEEP=0, TDATA=0, RVVIStall=0, DropCount=0.
//  Byte count: CSRCount = rvvi[XLEN+168 +: 12], clamped to MAX_CSRS;
//   Bytes = (72+5*XLEN)/8 + CSRCount*(XLEN+16)/8; Beats = ceil(Bytes/(AXIW/8)).
//  Payload is little-endian: beat i carries rvvi bytes [i*AXIW/8 .. i*AXIW/8+AXIW/8-1].
//  States: IDLE -> SEND -> (GAP>0 ? GAPWAIT : IDLE); GAPWAIT -> IDLE after GAP cycles.
//  IDLE: if En & valid at edge N, rvvi is captured in a W-bit holding register, Bytes/Beats are
//   latched, beat counter = 0, and state becomes SEND. TVALID rises in cycle N+1 with beat 0.
//  SEND: TVALID=1; TDATA = beat[beatcnt]; TLAST = (beatcnt == Beats-1); on TLAST, TKEEP has its
//   low (Bytes mod AXIW/8) bits set (all-ones if 0); otherwise TKEEP is all-ones.
//   Advance beatcnt only on TVALID&TREADY; TDATA/TKEEP/TLAST are held stable while TREADY=0.
//   Handshake on the last beat -> GAPWAIT (GAP>0) or IDLE; TVALID is 0 the following cycle.
//  GAPWAIT: counter counts GAP cycles, then state returns to IDLE.
//  RVVIStall = (state != IDLE), decoded from registered state only; no combinational path from
//   valid or TREADY.
//  Drops: valid & En while state != IDLE -> DropCount+1, saturating at 16'hFFFF; record is discarded.
//  En falling during SEND/GAPWAIT does not abort the frame; it only blocks new captures.
//  Reset mid-frame: next cycle is IDLE with TVALID=0, no TLAST emitted, DropCount cleared.
//  Beat counter width: $clog2(max Beats)+1; no wrap is possible within a frame.
// TESTING (XLEN=64, MAX_CSRS=3, AXIW=32, GAP=2 unless stated)
//  1. CSRCount=0 record, TREADY=1 -> 49 bytes, 13 beats, TLAST on beat 12 with TKEEP=4'b0001;
//     RVVIStall high for 13+2 cycles.
//  2. CSRCount=3 -> 79 bytes, 20 beats, last TKEEP=4'b0111; beat 0 TDATA = PC[31:0].
//  3. CSRCount=1, TREADY toggled 1,0,0,1,... -> 59 bytes, 15 beats, TDATA/TKEEP/TLAST held on every
//     stalled cycle, no beat duplicated or skipped.
//  4. valid pulsed on 3 cycles during SEND -> DropCount=3, the frame in flight is unchanged; with
//     DropCount preset near 16'hFFFF, it saturates at 16'hFFFF.
//  5. CSRCount field=12'd7 -> clamped to 3, 20 beats. En=0 with valid=1 -> no frame, DropCount=0.
//  6. reset asserted at beat 5 -> TVALID=0 next cycle, RVVIStall=0; a new valid is captured
//     normally one cycle after reset deasserts.

Source files
------------

// File: rtl/rvvi_packetizer.sv
// Captures one compressed RVVI record per retired instruction and streams its meaningful bytes
// as a single AXI4-Stream frame, stalling the core while the frame is in flight.
module rvvi_packetizer #(
  parameter int XLEN     = 64,
  parameter int MAX_CSRS = 5,
  parameter int AXIW     = 32,
  parameter int GAP      = 4,
  localparam int W       = 72 + 5*XLEN + MAX_CSRS*(XLEN + 16)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En,
  input  logic              valid,
  input  logic [W-1:0]      rvvi,
  output logic [AXIW-1:0]   TDATA,
  output logic [AXIW/8-1:0] TKEEP,
  output logic              TVALID,
  output logic              TLAST,
  input  logic              TREADY,
  output logic              RVVIStall,
  output logic [15:0]       DropCount,
  output logic [1:0]        state_o
);

  localparam int BPB        = AXIW / 8;
  localparam int BASE_BYTES = (72 + 5*XLEN) / 8;
  localparam int CSR_BYTES  = (XLEN + 16) / 8;
  localparam int MAX_BYTES  = BASE_BYTES + MAX_CSRS*CSR_BYTES;
  localparam int MAX_BEATS  = (MAX_BYTES + BPB - 1) / BPB;
  localparam int BW         = $clog2(MAX_BYTES + 1);
  localparam int CW         = $clog2(MAX_BEATS) + 1;
  localparam int HW         = MAX_BEATS * AXIW;
  localparam int GW         = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int CSR_LSB    = XLEN + 168;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAPWAIT = 2'd2} state_e;

  // Stream handshake: a beat transfers on a rising edge where TVALID & TREADY; once TVALID is
  // raised, TDATA/TKEEP/TLAST stay put until that transfer happens.
  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [BW-1:0]   bytes_q, bytes_d;
  logic [CW-1:0]   beats_q, beats_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [15:0]     drop_q, drop_d;

  logic [11:0]     csr_raw, csr_cnt;
  logic [BW-1:0]   bytes_in;
  logic [CW-1:0]   beats_in;
  logic            last_beat, accept;
  int              rem;
  logic [BPB-1:0]  last_keep;

  always_comb begin
    csr_raw  = rvvi[CSR_LSB +: 12];
    csr_cnt  = (csr_raw > 12'(MAX_CSRS)) ? 12'(MAX_CSRS) : csr_raw;
    bytes_in = BW'(BASE_BYTES + int'(csr_cnt) * CSR_BYTES);
    beats_in = CW'((int'(bytes_in) + BPB - 1) / BPB);

    last_beat = (beat_q == beats_q - 1'b1);
    rem       = int'(bytes_q) % BPB;
    for (int k = 0; k < BPB; k++) last_keep[k] = (rem == 0) || (k < rem);

    TVALID = (state_q == SEND);
    TLAST  = TVALID & last_beat;
    TKEEP  = TVALID ? (last_beat ? last_keep : '1) : '0;
    TDATA  = TVALID ? hold_q[int'(beat_q)*AXIW +: AXIW] : '0;
    accept = TVALID & TREADY;

    state_d = state_q;
    hold_d  = hold_q;
    bytes_d = bytes_q;
    beats_d = beats_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    drop_d  = drop_q;

    if (En && valid && state_q != IDLE && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (En && valid) begin
          hold_d  = HW'(rvvi);
          bytes_d = bytes_in;
          beats_d = beats_in;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (last_beat) begin
            beat_d = '0;
            gap_d  = '0;
            state_d = (GAP > 0) ? GAPWAIT : IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      GAPWAIT: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      bytes_q <= '0;
      beats_q <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bytes_q <= bytes_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      drop_q  <= drop_d;
    end
  end

  // Stall comes only from registered state, so valid/TREADY never reach it combinationally.
  assign RVVIStall = (state_q != IDLE);
  assign DropCount = drop_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_rvvi_packetizer.sv
// Randomized bench for rvvi_packetizer: a byte-level frame model feeds an expected-beat queue
// that a negedge monitor drains, alongside hold, stall and drop-count checks.
module tb_rvvi_packetizer;

  localparam int XLEN       = 64;
  localparam int MAX_CSRS   = 3;
  localparam int AXIW       = 32;
  localparam int GAP        = 2;
  localparam int W          = 72 + 5*XLEN + MAX_CSRS*(XLEN + 16);
  localparam int BPB        = AXIW / 8;
  localparam int CSR_LSB    = XLEN + 168;
  localparam int BASE_BYTES = (72 + 5*XLEN) / 8;
  localparam int CSR_BYTES  = (XLEN + 16) / 8;
  localparam int EW         = 1 + BPB + AXIW;

  logic             clk, reset, En, valid, TREADY;
  logic [W-1:0]     rvvi;
  logic [AXIW-1:0]  TDATA;
  logic [BPB-1:0]   TKEEP;
  logic             TVALID, TLAST, RVVIStall;
  logic [15:0]      DropCount;
  logic [1:0]       dbg_state;

  rvvi_packetizer #(.XLEN(XLEN), .MAX_CSRS(MAX_CSRS), .AXIW(AXIW), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .En(En), .valid(valid), .rvvi(rvvi),
    .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(TVALID), .TLAST(TLAST), .TREADY(TREADY),
    .RVVIStall(RVVIStall), .DropCount(DropCount), .state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic logic [W-1:0] rand_rec(input int csr);
    logic [W-1:0] r;
    for (int i = 0; i < W/8; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
    r[CSR_LSB +: 12] = 12'(csr);
    return r;
  endfunction

  // Reference: frame = first Bytes bytes of the record, packed BPB bytes per beat.
  task automatic push_frame(input logic [W-1:0] r);
    int cnt, nbytes, nbeats, idx;
    logic [EW-1:0] e;
    cnt = int'(r[CSR_LSB +: 12]);
    if (cnt > MAX_CSRS) cnt = MAX_CSRS;
    nbytes = BASE_BYTES + cnt * CSR_BYTES;
    nbeats = (nbytes + BPB - 1) / BPB;
    for (int i = 0; i < nbeats; i++) begin
      e = '0;
      for (int b = 0; b < BPB; b++) begin
        idx = i*BPB + b;
        if (idx < nbytes) begin
          e[b*8 +: 8]  = r[idx*8 +: 8];
          e[AXIW + b]  = 1'b1;
        end
      end
      e[EW-1] = (i == nbeats - 1);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  int              frame_beats = 0, last_frame_beats = 0, stall_run = 0, last_stall = 0, tvalid_cycles = 0;
  logic [AXIW-1:0] first_data;
  logic            prev_stalled = 1'b0, prev_last_hs = 1'b0;
  logic [EW:0]     prev_out;
  logic [EW-1:0]   mon_e;
  logic [AXIW-1:0] mon_d;

  always @(negedge clk) begin
    if (reset) begin
      prev_stalled = 1'b0;
      prev_last_hs = 1'b0;
      stall_run    = 0;
      frame_beats  = 0;
    end else begin
      if (prev_stalled) check_eq("hold_stable", {TVALID, TLAST, TKEEP, TDATA}, prev_out);
      if (prev_last_hs) check_eq("tvalid_after_last", TVALID, 1'b0);
      if (TVALID) tvalid_cycles++;
      if (TVALID && TREADY) begin
        check_eq("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_d = '0;
          for (int b = 0; b < BPB; b++)
            if (mon_e[AXIW + b]) mon_d[b*8 +: 8] = TDATA[b*8 +: 8];
          check_eq("beat", {TLAST, TKEEP, mon_d}, mon_e);
        end
        if (frame_beats == 0) first_data = TDATA;
        frame_beats++;
        if (TLAST) begin
          last_frame_beats = frame_beats;
          frame_beats = 0;
        end
      end
      prev_last_hs = TVALID && TREADY && TLAST;
      prev_stalled = TVALID && !TREADY;
      prev_out     = {TVALID, TLAST, TKEEP, TDATA};
      if (RVVIStall) stall_run++;
      else if (stall_run != 0) begin
        last_stall = stall_run;
        stall_run  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_record(input logic [W-1:0] r);
    rvvi  = r;
    valid = 1'b1;
    push_frame(r);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk); #1;
    check_eq("tvalid_rise", TVALID, 1'b1);
    check_eq("stall_rise", RVVIStall, 1'b1);
  endtask

  // mode 0: TREADY=1; 1: pattern 1,0,0; 2: random
  task automatic run_frame(input int mode, input int directed_drops, input bit random_drops);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      TREADY = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      valid = 1'b0;
      En    = 1'b1;
      if (exp_q.size() != 0 && k < 2*directed_drops && k % 2 == 1) begin
        valid = 1'b1;
        rvvi  = rand_rec(1);
        exp_drop = sat_inc(exp_drop);
      end else if (random_drops && exp_q.size() != 0 && $urandom_range(0, 3) == 0) begin
        valid = 1'b1;
        rvvi  = rand_rec(2);
        En    = 1'($urandom_range(0, 1));
        if (En) exp_drop = sat_inc(exp_drop);
      end else if (random_drops) begin
        En = 1'($urandom_range(0, 1));
      end
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !RVVIStall) break;
    end
    valid = 1'b0;
    En    = 1'b1;
    check_eq("frame_drained", exp_q.size(), 0);
    check_eq("stall_released", RVVIStall, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] rec;
  int t0;

  initial begin
    reset = 1'b1; En = 1'b1; valid = 1'b0; rvvi = '0; TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check_eq("rst_tvalid", TVALID, 1'b0);
    check_eq("rst_tlast", TLAST, 1'b0);
    check_eq("rst_tkeep", TKEEP, '0);
    check_eq("rst_tdata", TDATA, '0);
    check_eq("rst_stall", RVVIStall, 1'b0);
    check_eq("rst_drop", DropCount, 0);

    // 49-byte record, full throughput
    rec = rand_rec(0);
    send_record(rec);
    run_frame(0, 0, 0);
    check_eq("t1_beats", last_frame_beats, 13);
    check_eq("t1_stall_len", last_stall, 13 + GAP);

    // all CSRs, beat 0 carries PC[31:0]
    rec = rand_rec(3);
    send_record(rec);
    run_frame(0, 0, 0);
    check_eq("t2_beats", last_frame_beats, 20);
    check_eq("t2_beat0_pc", first_data, rec[31:0]);

    // backpressure pattern
    rec = rand_rec(1);
    send_record(rec);
    run_frame(1, 0, 0);
    check_eq("t3_beats", last_frame_beats, 15);

    // CSRCount field beyond MAX_CSRS
    rec = rand_rec(7);
    send_record(rec);
    run_frame(0, 0, 0);
    check_eq("t5_clamp_beats", last_frame_beats, 20);

    // three drops during a frame
    rec = rand_rec(3);
    send_record(rec);
    run_frame(0, 3, 0);
    check_eq("t4_drop3", DropCount, exp_drop);
    check_eq("t4_beats", last_frame_beats, 20);

    // reset mid-frame
    rec = rand_rec(2);
    send_record(rec);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      TREADY = 1'b1;
      if (frame_beats >= 5) break;
    end
    check_eq("t6_reached_beat5", frame_beats, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    exp_q.delete();
    exp_drop = 0;
    check_eq("t6_tvalid", TVALID, 1'b0);
    check_eq("t6_stall", RVVIStall, 1'b0);
    check_eq("t6_drop", DropCount, 0);
    rec = rand_rec(0);
    send_record(rec);
    run_frame(0, 0, 0);
    check_eq("t6_new_frame_beats", last_frame_beats, 13);

    // En=0 ignores valid entirely
    t0 = tvalid_cycles;
    En = 1'b0; valid = 1'b1; rvvi = rand_rec(1);
    repeat (6) @(posedge clk);
    #1 valid = 1'b0; En = 1'b1;
    @(negedge clk); #1;
    check_eq("en0_no_frame", tvalid_cycles - t0, 0);
    check_eq("en0_no_stall", RVVIStall, 1'b0);
    check_eq("en0_drop", DropCount, 0);

    // randomized frames with backpressure, En toggling and drop attempts
    for (int n = 0; n < 24; n++) begin
      rec = rand_rec($urandom_range(0, 5) == 0 ? $urandom_range(4, 4095) : $urandom_range(0, MAX_CSRS));
      En = 1'b1;
      send_record(rec);
      run_frame($urandom_range(0, 2), 0, 1);
      check_eq("rand_drop", DropCount, exp_drop);
    end

    // saturation: frame parked by TREADY=0 while valid stays high
    TREADY = 1'b0;
    rec = rand_rec(1);
    send_record(rec);
    rvvi = rand_rec(2);
    for (int k = 0; k < 65540; k++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      exp_drop = sat_inc(exp_drop);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk); #1;
    check_eq("drop_saturate", DropCount, exp_drop);
    check_eq("drop_saturate_max", DropCount, 16'hFFFF);
    run_frame(0, 0, 0);
    check_eq("sat_frame_beats", last_frame_beats, 15);
    check_eq("drop_held", DropCount, exp_drop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, exp_q size %0d", exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
